ps2_tx: RTL

- Host-to-device PS/2 transmitter for the v65C02 keyboard port.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- Drives the shared open-drain PS/2 clock and data lines through active-high pull-low enables.
- Sits beside the existing PS/2 receiver on the same two pads. The top level gates the receiver while tx_busy_o is high.

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_sync_edge.sv | 66 ++++++
 rtl/ps2_tx.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, frame constants and parity helper
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    localparam logic PS2_START_BIT = 1'b0;
    localparam logic PS2_STOP_BIT  = 1'b1;
    localparam int   FRAME_BITS    = 11;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// rtl/ps2_sync_edge.sv - PS/2 pad synchronizer with optional stability filter and falling-edge pulse
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit FILTER_EN   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic pad_i,
    output logic level_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   level;

    // Idle PS/2 lines are pulled high, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= pad_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    generate
        if (FILTER_EN) begin : g_filter
            logic [3:0] stable_cnt_q;
            logic       filt_q;

            // Level follows the input only after 8 consecutive differing samples.
            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    stable_cnt_q <= '0;
                    filt_q       <= 1'b1;
                end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
                    stable_cnt_q <= '0;
                end else if (stable_cnt_q == 4'd7) begin
                    stable_cnt_q <= '0;
                    filt_q       <= sync_q[SYNC_STAGES-1];
                end else begin
                    stable_cnt_q <= stable_cnt_q + 4'd1;
                end
            end

            assign level = filt_q;
        end else begin : g_raw
            assign level = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level;
        end
    end

    assign level_o = level;
    assign fall_o  = prev_q & ~level;

endmodule

// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - PS/2 host-to-device command transmitter (optional clock filter: PS2_TX_CLK_FILTER_EN)
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       tx_stb_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_rdy_o,
    output logic       tx_busy_o,
    output logic       tx_done_stb_o,
    output logic       tx_err_stb_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_din_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_dout_oe_o
);

`ifdef PS2_TX_CLK_FILTER_EN
    localparam bit CLK_FILTER = 1'b1;
`else
    localparam bit CLK_FILTER = 1'b0;
`endif

    localparam int IW = $clog2(INHIBIT_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    ps2_state_t            state_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic [IW-1:0]         inhib_cnt_q;
    logic [TW-1:0]         to_cnt_q;
    logic [3:0]            edge_cnt_q;
    logic                  rdy_q;
    logic                  done_q;
    logic                  err_q;
    logic                  clk_oe_q;
    logic                  dout_oe_q;

    logic clk_level;
    logic clk_fall;
    logic din_level;
    logic din_fall_unused;

    ps2_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_EN   (CLK_FILTER)
    ) u_clk_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .pad_i   (ps2_clk_i),
        .level_o (clk_level),
        .fall_o  (clk_fall)
    );

    ps2_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_EN   (1'b0)
    ) u_din_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .pad_i   (ps2_din_i),
        .level_o (din_level),
        .fall_o  (din_fall_unused)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            shift_q     <= '1;
            inhib_cnt_q <= '0;
            to_cnt_q    <= '0;
            edge_cnt_q  <= '0;
            rdy_q       <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            clk_oe_q    <= 1'b0;
            dout_oe_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;

            // Timeout wins over any edge seen in the same cycle.
            if ((state_q inside {SEND, ACK, WAIT_IDLE}) && to_cnt_q == TO_LAST) begin
                clk_oe_q  <= 1'b0;
                dout_oe_q <= 1'b0;
                err_q     <= 1'b1;
                rdy_q     <= 1'b1;
                state_q   <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        clk_oe_q  <= 1'b0;
                        dout_oe_q <= 1'b0;
                        if (tx_stb_i) begin
                            shift_q     <= {PS2_STOP_BIT, odd_parity(tx_data_i), tx_data_i, PS2_START_BIT};
                            inhib_cnt_q <= '0;
                            edge_cnt_q  <= '0;
                            rdy_q       <= 1'b0;
                            clk_oe_q    <= 1'b1;
                            state_q     <= INHIBIT;
                        end
                    end

                    INHIBIT: begin
                        if (inhib_cnt_q == INH_LAST) begin
                            clk_oe_q <= 1'b0;
                            to_cnt_q <= '0;
                            state_q  <= SEND;
                        end else begin
                            inhib_cnt_q <= inhib_cnt_q + 1'b1;
                            // Start bit goes out during the last inhibit cycle.
                            if (inhib_cnt_q == INH_LAST - 1'b1) begin
                                dout_oe_q <= ~shift_q[0];
                            end
                        end
                    end

                    SEND: begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                        if (clk_fall) begin
                            shift_q    <= {1'b1, shift_q[FRAME_BITS-1:1]};
                            dout_oe_q  <= ~shift_q[1];
                            edge_cnt_q <= edge_cnt_q + 4'd1;
                            if (edge_cnt_q == 4'd9) begin
                                state_q <= ACK;
                            end
                        end
                    end

                    ACK: begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                        if (clk_fall) begin
                            if (!din_level) begin
                                state_q <= WAIT_IDLE;
                            end else begin
                                err_q   <= 1'b1;
                                rdy_q   <= 1'b1;
                                state_q <= IDLE;
                            end
                        end
                    end

                    WAIT_IDLE: begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                        if (clk_level && din_level) begin
                            done_q  <= 1'b1;
                            rdy_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end

                    default: begin
                        clk_oe_q  <= 1'b0;
                        dout_oe_q <= 1'b0;
                        rdy_q     <= 1'b1;
                        state_q   <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_rdy_o      = rdy_q;
    assign tx_busy_o     = ~rdy_q;
    assign tx_done_stb_o = done_q;
    assign tx_err_stb_o  = err_q;
    assign ps2_clk_oe_o  = clk_oe_q;
    assign ps2_dout_oe_o = dout_oe_q;

endmodule
